// File: rtl/card_pkg.sv
// Shared types and constants for the memory-game turn controller.
// Card word layout: [4:2] symbol, [1:0] state.
package card_pkg;

    typedef logic [4:0] card_t;

    localparam logic [1:0] CARD_CLOSED  = 2'b00;
    localparam logic [1:0] CARD_OPEN    = 2'b01;
    localparam logic [1:0] CARD_MATCHED = 2'b10;

    localparam int N_CARDS_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK1,
        ST_PICK2,
        ST_SHOW,
        ST_VERIFY,
        ST_WAIT_DONE,
        ST_OVER
    } state_t;

    function automatic logic [1:0] card_state(input card_t c);
        return c[1:0];
    endfunction

endpackage

// File: rtl/cursor_ctrl.sv
// Wrap-around board cursor: one step left or right per enabled cycle;
// simultaneous left and right cancel out.
module cursor_ctrl #(
    parameter int N_POS = 16,
    parameter int W     = $clog2(N_POS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_en,
    input  logic         i_left,
    input  logic         i_right,
    output logic [W-1:0] o_cursor
);

    logic [W-1:0] r_cursor;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cursor <= '0;
        end else if (i_clear) begin
            r_cursor <= '0;
        end else if (i_en && (i_left ^ i_right)) begin
            if (i_right)
                r_cursor <= (r_cursor == W'(N_POS - 1)) ? '0 : r_cursor + W'(1);
            else
                r_cursor <= (r_cursor == '0) ? W'(N_POS - 1) : r_cursor - W'(1);
        end
    end

    assign o_cursor = r_cursor;

endmodule

// File: rtl/card_flip_controller.sv
// Player-turn controller for the memory game, upstream of the pair verifier.
// Optional turn timeout is built in when TURN_TIMEOUT_EN is defined.
module card_flip_controller
    import card_pkg::*;
#(
    parameter int N_CARDS        = N_CARDS_DEFAULT,
    parameter int SHOW_CYCLES    = 50000000,
    parameter int TIMEOUT_CYCLES = 750000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_board_load,
    input  logic [5*N_CARDS-1:0]       i_board_in,
    input  logic                       i_btn_left,
    input  logic                       i_btn_right,
    input  logic                       i_btn_sel,
    output logic [5*N_CARDS-1:0]       o_board_out,
    output logic [$clog2(N_CARDS)-1:0] o_cursor,
    output logic                       o_verify_start,
    input  logic                       i_verify_done,
    input  logic                       i_verify_match,
    input  logic [5*N_CARDS-1:0]       i_verify_board,
    output logic                       o_cur_player,
    output logic                       o_game_over,
    output logic                       o_turn_timeout
);

    localparam int CUR_W   = $clog2(N_CARDS);
    localparam int CNT_MAX = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           r_state, w_next_state;
    card_t            r_board [N_CARDS];
    card_t            w_board_in [N_CARDS];
    card_t            w_vboard [N_CARDS];
    logic [CUR_W-1:0] r_cursor, r_pos1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_player;
    logic             w_load, w_open, w_show_start, w_take_verify, w_timeout;
    logic             w_cursor_en, w_cursor_closed, w_all_matched, w_turn_expired;

    for (genvar g = 0; g < N_CARDS; g++) begin : g_pack
        assign w_board_in[g]       = i_board_in[5*g +: 5];
        assign w_vboard[g]         = i_verify_board[5*g +: 5];
        assign o_board_out[5*g +: 5] = r_board[g];
    end

    cursor_ctrl #(.N_POS(N_CARDS), .W(CUR_W)) u_cursor (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_load),
        .i_en     (w_cursor_en),
        .i_left   (i_btn_left),
        .i_right  (i_btn_right),
        .o_cursor (r_cursor)
    );

    assign w_cursor_closed = (card_state(r_board[r_cursor]) == CARD_CLOSED);

    always_comb begin
        w_all_matched = 1'b1;
        for (int i = 0; i < N_CARDS; i++)
            if (card_state(w_vboard[i]) != CARD_MATCHED) w_all_matched = 1'b0;
    end

`ifdef TURN_TIMEOUT_EN
    assign w_turn_expired = (r_cnt == '0);
`else
    assign w_turn_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_load        = 1'b0;
        w_open        = 1'b0;
        w_show_start  = 1'b0;
        w_take_verify = 1'b0;
        w_timeout     = 1'b0;
        w_cursor_en   = 1'b0;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (i_board_load) begin
                    w_load       = 1'b1;
                    w_next_state = ST_PICK1;
                end
            end
            ST_PICK1: begin
                w_cursor_en = 1'b1;
                if (w_turn_expired) begin
                    w_timeout = 1'b1;
                end else if (i_btn_sel && w_cursor_closed) begin
                    w_open       = 1'b1;
                    w_next_state = ST_PICK2;
                end
            end
            ST_PICK2: begin
                w_cursor_en = 1'b1;
                if (w_turn_expired) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_PICK1;
                end else if (i_btn_sel && w_cursor_closed && (r_cursor != r_pos1)) begin
                    w_open       = 1'b1;
                    w_show_start = 1'b1;
                    w_next_state = ST_SHOW;
                end
            end
            ST_SHOW:   if (r_cnt == '0) w_next_state = ST_VERIFY;
            ST_VERIFY: w_next_state = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (i_verify_done) begin
                    w_take_verify = 1'b1;
                    w_next_state  = w_all_matched ? ST_OVER : ST_PICK1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: the board is a small register file that must come out of reset
    // all-closed, so unlike a RAM it is cleared element by element.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CARDS; i++) r_board[i] <= '0;
        end else if (w_load) begin
            r_board <= w_board_in;
        end else if (w_open) begin
            r_board[r_cursor][1:0] <= CARD_OPEN;
        end else if (w_take_verify) begin
            r_board <= w_vboard;
        end else if (w_timeout) begin
            for (int i = 0; i < N_CARDS; i++)
                if (card_state(r_board[i]) == CARD_OPEN) r_board[i][1:0] <= CARD_CLOSED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_player <= 1'b0;
            r_pos1   <= '0;
        end else begin
            if (w_load)
                r_player <= 1'b0;
            else if ((w_take_verify && !i_verify_match) || w_timeout)
                r_player <= ~r_player;
            if (w_open && (r_state == ST_PICK1))
                r_pos1 <= r_cursor;
        end
    end

    // One down-counter serves both the show delay and the turn timeout;
    // the two never run in the same state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (w_show_start)
            r_cnt <= CNT_W'(SHOW_CYCLES - 1);
`ifdef TURN_TIMEOUT_EN
        else if (w_load || w_open || w_take_verify || w_timeout)
            r_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
        else if (r_cnt != '0)
            r_cnt <= r_cnt - CNT_W'(1);
    end

`ifdef TURN_TIMEOUT_EN
    logic r_turn_timeout;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_turn_timeout <= 1'b0;
        else     r_turn_timeout <= w_timeout;
    end
    assign o_turn_timeout = r_turn_timeout;
`else
    assign o_turn_timeout = 1'b0;
`endif

    assign o_cursor       = r_cursor;
    assign o_cur_player   = r_player;
    assign o_verify_start = (r_state == ST_VERIFY);
    assign o_game_over    = (r_state == ST_OVER);

endmodule
